// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms at 27 MHz
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  // Registered control outputs, all derived from the state alone.
  typedef struct packed {
    logic pll_reset;
    logic sys_reset;
    logic ready;
    logic fault;
  } seq_out_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Output levels for a given state; WAIT_LOCK and STABLE look identical.
  function automatic seq_out_t decode_outputs(input seq_state_e st);
    seq_out_t o;
    o = '{pll_reset: 1'b0, sys_reset: 1'b1, ready: 1'b0, fault: 1'b0};
    case (st)
      ST_RST_PLL: o.pll_reset = 1'b1;
      ST_RUN: begin
        o.sys_reset = 1'b0;
        o.ready     = 1'b1;
      end
      ST_FAULT: begin
        o.pll_reset = 1'b1;
        o.fault     = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clkin domain.
module pll_lock_sync (
  input  logic clkin_i,
  input  logic reset_i,
  input  logic lock_i,
  output logic lock_s_o
);

  logic meta_q;
  logic sync_q;

  // Shift lock through two flops; both clear on reset.
  always_ff @(posedge clkin_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync_q takes the pre-edge meta_q, giving two real stages.
      meta_q <= lock_i;
      sync_q <= meta_q;
    end
  end

  assign lock_s_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock with
// bounded retries, then releases the downstream system reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lost_count
);

  localparam int unsigned MAX_CYCLES =
    max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first saw lock_s=1 is the first of the stable
  // window, so STABLE itself only needs LOCK_STABLE_CYCLES-1 more cycles.
  localparam logic [CNT_W-1:0] STABLE_LAST  =
    CNT_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  seq_out_t         out_q, out_d;
  logic             lock_s;

  pll_lock_sync u_lock_sync (
    .clkin_i (clkin),
    .reset_i (reset),
    .lock_i  (lock),
    .lock_s_o(lock_s)
  );

  // Next-state, counter, retry/loss bookkeeping and output decode of the next state.
  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    unique case (state_q)
      ST_RST_PLL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RST_PLL;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      ST_STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RST_PLL;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RST_PLL;
    endcase

    // Restart wins over any lock event or timeout decided above.
    if (restart) begin
      state_d = ST_RST_PLL;
      retry_d = '0;
      lost_d  = lost_q;
    end

    // Any state entry, including a restart into RST_PLL, starts a fresh count.
    if (restart || (state_d != state_q)) cnt_d = '0;

    out_d = decode_outputs(state_d);
  end

  // State, counter and registered outputs; synchronous reset discards all progress.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= ST_RST_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= '0;
      out_q   <= decode_outputs(ST_RST_PLL);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      out_q   <= out_d;
    end
  end

  assign pll_reset   = out_q.pll_reset;
  assign sys_reset   = out_q.sys_reset;
  assign ready       = out_q.ready;
  assign fault       = out_q.fault;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_reset is held per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 27000: cycles allowed for lock (1 ms at 27 MHz).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: PLL re-reset attempts before fault.
REQ-005 SHALL have port clkin, input, 1: the single clock (27 MHz board oscillator); everything is on this clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port lock, input, 1: PLL lock, asynchronous to clkin.
REQ-008 SHALL have port restart, input, 1: single-cycle request to re-run the full sequence.
REQ-009 SHALL have port pll_reset, output, 1: drives the PLL reset pin.
REQ-010 SHALL have port sys_reset, output, 1: active-high reset for downstream logic.
REQ-011 SHALL have port ready, output, 1: high only in RUN.
REQ-012 SHALL have port fault, output, 1: high only in FAULT.
REQ-013 SHALL have port retry_count, output, 2: attempts consumed in the current sequence.
REQ-014 SHALL have port lost_count, output, 8: count of lock losses seen in RUN, saturating at 255.

Function
REQ-015 SHALL synchronize lock through two flops (lock_s); lock_s lags lock by 2 cycles.
REQ-016 SHALL implement the states RST_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with one shared cycle counter cleared on every state entry.
REQ-017 SHALL register all outputs as a decode of the next state, so outputs change on the same edge as the state.
REQ-018 SHALL, in RST_PLL, drive pll_reset=1 and sys_reset=1, and go to WAIT_LOCK after exactly PLL_RST_CYCLES cycles.
REQ-019 SHALL, in WAIT_LOCK, drive pll_reset=0 and go to STABLE on lock_s=1.
REQ-020 SHALL, in WAIT_LOCK, act on LOCK_TIMEOUT_CYCLES elapsed without lock_s as follows: if retry_count equals MAX_RETRIES, go to FAULT; otherwise increment retry_count and go to RST_PLL.
REQ-021 SHALL, in STABLE, go to RUN once lock_s has been 1 for LOCK_STABLE_CYCLES consecutive cycles.
REQ-022 SHALL, in STABLE, go back to WAIT_LOCK on any lock_s=0 cycle, with retry_count unchanged and the timeout restarting.
REQ-023 SHALL, in RUN, drive sys_reset=0 and ready=1, and clear retry_count on entry.
REQ-024 SHALL, in RUN, on lock_s=0, go to RST_PLL and increment lost_count, saturating at 255.
REQ-025 SHALL, in FAULT, hold pll_reset=1, sys_reset=1 and fault=1, and leave only via reset or restart.
REQ-026 SHALL, on restart=1 in any state, go to RST_PLL and clear retry_count; restart takes priority over a simultaneous lock event or timeout.
REQ-027 SHALL size the counter by $clog2 of the largest cycle parameter; the counter never wraps, since each limit causes a state exit.

Reset
REQ-028 SHALL, on reset=1 at a clkin edge, enter RST_PLL with pll_reset=1, sys_reset=1, ready=0, fault=0, retry_count=0, lost_count=0, counter=0 and lock synchronizer flops=0.
REQ-029 SHALL, on reset asserted mid-sequence in any state, discard all progress; the PLL reset count restarts after reset deasserts.

Structure
REQ-030 SHALL take the state enum and default parameter constants from shared package pll_seq_pkg.
REQ-031 SHALL implement the two-flop synchronizer as sub-module pll_lock_sync, reset value 0.

Verification
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-032 SHALL cover nominal lock: lock rises 10 cycles after pll_reset falls and holds -> ready=1 and sys_reset=0 exactly 10 cycles after the lock edge, retry_count=0.
REQ-033 SHALL cover no lock: lock held 0 -> three 4-cycle pll_reset pulses, then fault=1 with retry_count=2, pll_reset=1 and sys_reset=1.
REQ-034 SHALL cover a glitch during STABLE: lock low for 1 cycle after 5 stable cycles -> return to WAIT_LOCK, ready delayed by a fresh 8-cycle window, retry_count unchanged.
REQ-035 SHALL cover lock loss in RUN: lock falls -> sys_reset=1 and ready=0 within 3 cycles, lost_count=1, a 4-cycle pll_reset pulse, then re-lock reaches RUN.
REQ-036 SHALL cover restart from FAULT: one-cycle restart -> fault=0 next cycle, retry_count=0, pll_reset pulse of 4 cycles.
REQ-037 SHALL cover reset mid-WAIT_LOCK: reset for 1 cycle -> all outputs at reset values next cycle and lost_count=0.
